// File: rtl/memory_bus_arbiter_pkg.sv
// Shared types and defaults for the CPU/FPU memory bus arbiter.
// Owner encoding doubles as the bus_control mux select value.
package memory_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TURN      = 2'd1,
        ST_GRANT_CPU = 2'd2,
        ST_GRANT_FPU = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_FPU = 1'b1
    } owner_e;

    localparam int DEF_MAX_HOLD    = 16;
    localparam int DEF_TURN_CYCLES = 2;
    localparam int HOLD_W          = 8;
    localparam int TURN_W          = 4;

    // Round-robin pick: on a tie the side that did not own the bus last wins.
    function automatic owner_e rr_pick(input logic req_c, input logic req_f,
                                       input owner_e last_owner);
        if (req_c && req_f)
            return (last_owner == OWNER_CPU) ? OWNER_FPU : OWNER_CPU;
        else if (req_f)
            return OWNER_FPU;
        else
            return OWNER_CPU;
    endfunction

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating count of granted cycles; clear has priority over enable.
// Output is registered; value is 1 in the first granted cycle.
module arb_hold_counter #(
    parameter int W   = 8,
    parameter int MAX = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && (cnt_q != W'(MAX)))
            cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/memory_bus_arbiter.sv
// Two-master (CPU/FPU) memory bus arbiter with round-robin ties, turnaround dead time and yield hints.
// Grant latency 1 cycle when bus_control already points at the winner, else 1 + TURN_CYCLES.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int MAX_HOLD    = DEF_MAX_HOLD,
    parameter int TURN_CYCLES = DEF_TURN_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic cpu_req,
    input  logic cpu_done,
    input  logic fpu_req,
    input  logic fpu_done,
    output logic bus_control,
    output logic cpu_grant,
    output logic fpu_grant,
    output logic cpu_yield,
    output logic fpu_yield,
    output logic bus_busy
);

    arb_state_e         state_q, state_d;
    owner_e             last_owner_q, last_owner_d;
    owner_e             pick;
    logic [TURN_W-1:0]  turn_cnt_q, turn_cnt_d;
    logic [HOLD_W-1:0]  hold_q;
    logic               bus_control_q, bus_control_d;
    logic               cpu_grant_q, cpu_grant_d;
    logic               fpu_grant_q, fpu_grant_d;
    logic               cpu_yield_q, cpu_yield_d;
    logic               fpu_yield_q, fpu_yield_d;
    logic               busy_q, busy_d;
    logic               tgt_req;
    logic               hold_max;
    logic               granting_d;

    always_comb begin
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        turn_cnt_d    = turn_cnt_q;
        bus_control_d = bus_control_q;
        cpu_grant_d   = 1'b0;
        fpu_grant_d   = 1'b0;
        pick          = rr_pick(cpu_req, fpu_req, last_owner_q);
        tgt_req       = bus_control_q ? fpu_req : cpu_req;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req || fpu_req) begin
                    if (logic'(pick) == bus_control_q) begin
                        state_d     = (pick == OWNER_CPU) ? ST_GRANT_CPU : ST_GRANT_FPU;
                        cpu_grant_d = (pick == OWNER_CPU);
                        fpu_grant_d = (pick == OWNER_FPU);
                    end else begin
                        bus_control_d = logic'(pick);
                        state_d       = ST_TURN;
                        turn_cnt_d    = '0;
                    end
                end
            end
            ST_TURN: begin
                // The turnaround always runs to completion; a vanished request falls back to IDLE.
                if (turn_cnt_q == TURN_W'(TURN_CYCLES - 1)) begin
                    turn_cnt_d = '0;
                    if (tgt_req) begin
                        state_d     = bus_control_q ? ST_GRANT_FPU : ST_GRANT_CPU;
                        cpu_grant_d = !bus_control_q;
                        fpu_grant_d = bus_control_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + TURN_W'(1);
                end
            end
            ST_GRANT_CPU: begin
                if (cpu_done || !cpu_req) begin
                    last_owner_d = OWNER_CPU;
                    if (fpu_req) begin
                        bus_control_d = 1'b1;
                        state_d       = ST_TURN;
                        turn_cnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cpu_grant_d = 1'b1;
                end
            end
            ST_GRANT_FPU: begin
                if (fpu_done || !fpu_req) begin
                    last_owner_d = OWNER_FPU;
                    if (cpu_req) begin
                        bus_control_d = 1'b0;
                        state_d       = ST_TURN;
                        turn_cnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    fpu_grant_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // hold_q >= MAX_HOLD-1 while staying granted means the next granted cycle is number MAX_HOLD.
        hold_max    = (hold_q >= HOLD_W'(MAX_HOLD - 1));
        cpu_yield_d = cpu_grant_d && (cpu_yield_q || (cpu_grant_q && hold_max && fpu_req));
        fpu_yield_d = fpu_grant_d && (fpu_yield_q || (fpu_grant_q && hold_max && cpu_req));
        busy_d      = cpu_grant_d || fpu_grant_d || (state_d == ST_TURN);
    end

    assign granting_d = cpu_grant_d || fpu_grant_d;

    arb_hold_counter #(
        .W   (HOLD_W),
        .MAX (MAX_HOLD)
    ) u_hold (
        .clk   (clk),
        .rst   (rst),
        .clr_i (!granting_d),
        .en_i  (granting_d),
        .cnt_o (hold_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            last_owner_q  <= OWNER_FPU;
            turn_cnt_q    <= '0;
            bus_control_q <= 1'b0;
            cpu_grant_q   <= 1'b0;
            fpu_grant_q   <= 1'b0;
            cpu_yield_q   <= 1'b0;
            fpu_yield_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            turn_cnt_q    <= turn_cnt_d;
            bus_control_q <= bus_control_d;
            cpu_grant_q   <= cpu_grant_d;
            fpu_grant_q   <= fpu_grant_d;
            cpu_yield_q   <= cpu_yield_d;
            fpu_yield_q   <= fpu_yield_d;
            busy_q        <= busy_d;
        end
    end

    assign bus_control = bus_control_q;
    assign cpu_grant   = cpu_grant_q;
    assign fpu_grant   = fpu_grant_q;
    assign cpu_yield   = cpu_yield_q;
    assign fpu_yield   = fpu_yield_q;
    assign bus_busy    = busy_q;

endmodule
